// File: rtl/vga_fb_arbiter.sv
// 640x480@60 scan-out from a 160x120x8 screen RAM (4x4 pixel replication), sharing the RAM port
// with a game-logic writer. Define WR_DURING_ACTIVE_EN to let writes use non-fetch active cycles.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FB_W     = 160,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk_25m,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        pix_data,
    output logic              valid,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_vld_q;
    logic [7:0]        pix_q, pix_d;
    logic [2:0]        act_dly_q, hs_dly_q, vs_dly_q;

    logic              act, hs_n, vs_n, disp_need, grant;
    logic [ADDR_W-1:0] disp_row, disp_col, disp_addr;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
    end

    assign act  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hs_n = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));

`ifdef WR_DURING_ACTIVE_EN
    // One fetch per 4-pixel group; the other three slots are free for the writer.
    assign disp_need = act && (h_q[1:0] == 2'b00);
`else
    assign disp_need = act;
`endif

    // !wr_ack_q stops a second grant while the writer is still dropping its request.
    assign grant = wr_req && !disp_need && !wr_ack_q;

    assign disp_row  = ADDR_W'(v_q >> 2);
    assign disp_col  = ADDR_W'(h_q >> 2);
    assign disp_addr = disp_row * ADDR_W'(FB_W) + disp_col;

    always_comb begin
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        wr_ack_d    = 1'b0;
        if (disp_need) begin
            ram_re_d   = 1'b1;
            ram_addr_d = disp_addr;
        end else if (grant) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            wr_ack_d    = 1'b1;
        end
    end

    // Pixel register only loads when the RAM output belongs to a display fetch.
    assign pix_d = rd_vld_q ? ram_rdata : pix_q;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            ram_addr_q  <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            pix_q       <= '0;
            act_dly_q   <= '0;
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            ram_addr_q  <= ram_addr_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            wr_ack_q    <= wr_ack_d;
            rd_vld_q    <= ram_re_q;
            pix_q       <= pix_d;
            act_dly_q   <= {act_dly_q[1:0], act};
            hs_dly_q    <= {hs_dly_q[1:0], hs_n};
            vs_dly_q    <= {vs_dly_q[1:0], vs_n};
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_re      = ram_re_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign wr_ack      = wr_ack_q;
    assign pix_data    = pix_q;
    assign valid       = act_dly_q[2];
    assign hsync       = hs_dly_q[2];
    assign vsync       = vs_dly_q[2];
    assign frame_start = (h_q == '0) && (v_q == VW'(V_ACTIVE));
endmodule
